// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets, bit
// positions and the default window base.
package mmio_timer_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_FF00;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_COUNT    = 8'h04;
  localparam logic [7:0] OFF_COMPARE  = 8'h08;
  localparam logic [7:0] OFF_STATUS   = 8'h0C;
  localparam logic [7:0] OFF_PRESCALE = 8'h10;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IRQEN = 1;
  localparam int CTRL_AUTO  = 2;

  localparam int ST_MATCH = 0;
  localparam int ST_OVF   = 1;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_timer_tick_gen.sv
// Prescaler: counts 0..presc while enabled and emits a one-cycle tick
// whenever the counter sits at presc.
module tick_gen #(
  parameter int PRESC_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  assign tick = en & (cnt_q == presc);

  // next prescaler count; a register write or disable parks it at zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == presc) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Timer/compare peripheral on the CPU data bus: prescaled 32-bit counter,
// compare register, sticky status and a level interrupt.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          PRESC_W   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr,
  input  logic        rd,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  logic               sel_s;
  logic [7:0]         off_s;
  logic               wr_sel_s;
  logic               tick_s;
  logic               presc_clr_s;
  logic               match_set_s;
  logic               ovf_set_s;
  logic [1:0]         status_clr_s;
  logic [31:0]        rd_mux_s;

  logic [2:0]         ctrl_q,    ctrl_d;
  logic [31:0]        count_q,   count_d;
  logic [31:0]        compare_q, compare_d;
  logic [1:0]         status_q,  status_d;
  logic [PRESC_W-1:0] presc_q,   presc_d;
  logic [31:0]        rdata_q,   rdata_d;
  logic               hit_q,     hit_d;

  assign sel_s       = (addr[31:8] == BASE_ADDR[31:8]) && (addr[1:0] == 2'b00);
  assign off_s       = addr[7:0];
  assign wr_sel_s    = wr & sel_s;
  assign presc_clr_s = wr_sel_s && ((off_s == OFF_CTRL) || (off_s == OFF_PRESCALE));

  tick_gen #(.PRESC_W(PRESC_W)) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .en    (ctrl_q[CTRL_EN]),
    .clr   (presc_clr_s),
    .presc (presc_q),
    .tick  (tick_s)
  );

  // software-written registers and the W1C mask for STATUS
  always_comb begin
    ctrl_d       = ctrl_q;
    compare_d    = compare_q;
    presc_d      = presc_q;
    status_clr_s = 2'b00;
    if (wr_sel_s) begin
      case (off_s)
        OFF_CTRL:     ctrl_d       = wdata[2:0];
        OFF_COMPARE:  compare_d    = wdata;
        OFF_STATUS:   status_clr_s = wdata[1:0];
        OFF_PRESCALE: presc_d      = wdata[PRESC_W-1:0];
        default:      ctrl_d       = ctrl_q;
      endcase
    end else begin
      status_clr_s = 2'b00;
    end
  end

  // a COUNT write wins over the tick and suppresses that tick's flags
  always_comb begin
    count_d     = count_q;
    match_set_s = 1'b0;
    ovf_set_s   = 1'b0;
    if (wr_sel_s && (off_s == OFF_COUNT)) begin
      count_d = wdata;
    end else if (tick_s) begin
      if (count_q == compare_q) begin
        match_set_s = 1'b1;
        count_d     = ctrl_q[CTRL_AUTO] ? 32'd0 : count_q + 32'd1;
      end else if (count_q == 32'hFFFF_FFFF) begin
        ovf_set_s = 1'b1;
        count_d   = 32'd0;
      end else begin
        count_d = count_q + 32'd1;
      end
    end else begin
      count_d = count_q;
    end
  end

  // hardware set dominates a same-edge write-1-clear
  always_comb begin
    status_d           = status_q;
    status_d[ST_MATCH] = (status_q[ST_MATCH] & ~status_clr_s[ST_MATCH]) | match_set_s;
    status_d[ST_OVF]   = (status_q[ST_OVF]   & ~status_clr_s[ST_OVF])   | ovf_set_s;
  end

  // read mux over pre-edge register values
  always_comb begin
    case (off_s)
      OFF_CTRL:     rd_mux_s = {29'd0, ctrl_q};
      OFF_COUNT:    rd_mux_s = count_q;
      OFF_COMPARE:  rd_mux_s = compare_q;
      OFF_STATUS:   rd_mux_s = {30'd0, status_q};
      OFF_PRESCALE: rd_mux_s = 32'(presc_q);
      default:      rd_mux_s = 32'd0;
    endcase
    if (rd && sel_s) begin
      rdata_d = rd_mux_s;
      hit_d   = 1'b1;
    end else begin
      rdata_d = 32'd0;
      hit_d   = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_q    <= 3'd0;
      count_q   <= 32'd0;
      compare_q <= COMPARE_RST;
      status_q  <= 2'd0;
      presc_q   <= '0;
      rdata_q   <= 32'd0;
      hit_q     <= 1'b0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      presc_q   <= presc_d;
      rdata_q   <= rdata_d;
      hit_q     <= hit_d;
    end
  end

  assign rdata = rdata_q;
  assign hit   = hit_q;
  assign irq   = status_q[ST_MATCH] & ctrl_q[CTRL_IRQEN];

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped timer/compare peripheral. It is the responder on the CPU's data-memory bus, alongside Memoria: the CPU drives address, write strobe and store data; this block decodes its window and returns load data.
- Provides a free-running prescaled 32-bit counter, a compare register, sticky status flags and a level interrupt toward ctrl_unit.
- Read timing is the same as Memoria: data is valid one cycle after the address, so the existing memory wait state in the control FSM covers it.

Parameters:
- BASE_ADDR, 32'h0000_FF00, base of the 256-byte register window (low 8 bits must be 0).
- PRESC_W, 16, width of the prescaler register and the prescaler counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising clock edge.
- addr  in  32  byte address from the CPU (the PC/ALU address path).
- wr  in  1  store strobe (MEM_write).
- rd  in  1  load strobe.
- wdata  in  32  store data.
- rdata  out  32  load data, registered.
- hit  out  1  registered; high one cycle after an access that decoded into the window. The top level uses it to select rdata over the MEM_out data.
- irq  out  1  level interrupt = STATUS.match & CTRL.irqen.

Behaviour:
- Decode: sel = (addr[31:8]==BASE_ADDR[31:8]) & (addr[1:0]==0). Unaligned or out-of-window accesses are ignored: no write, rdata=0, hit=0.
- Register map (byte offsets):
  - 0x00 CTRL: bit0 en, bit1 irqen, bit2 autoreload; other bits read 0.
  - 0x04 COUNT: read/write.
  - 0x08 COMPARE: read/write.
  - 0x0C STATUS: bit0 match, bit1 ovf; write-1-to-clear.
  - 0x10 PRESCALE: [PRESC_W-1:0], zero-extended on read.
  - Other offsets read 0; writes to them are dropped.
- Reset values: CTRL=0, COUNT=0, COMPARE=32'hFFFF_FFFF, STATUS=0, PRESCALE=0, prescaler counter=0, rdata=0, hit=0, irq=0.
- Read timing:
  - If rd & sel at edge N, then rdata holds the register value sampled before edge N, and hit=1, during cycle N+1.
  - Otherwise rdata=0 and hit=0 in the following cycle.
- Write timing: if wr & sel at edge N, the register is updated at edge N. If rd and wr are both high, the write happens and rdata returns the old value.
- Tick generation:
  - While en=1, the prescaler counter counts 0..PRESCALE, then wraps to 0.
  - tick=1 in the cycle the prescaler counter equals PRESCALE. PRESCALE=0 gives a tick every cycle.
  - While en=0, the prescaler counter holds at 0 and there are no ticks.
  - A write to PRESCALE or CTRL clears the prescaler counter.
- Count on tick:
  - If COUNT==COMPARE: set match; COUNT becomes 0 if autoreload=1, otherwise COUNT+1.
  - Else if COUNT==32'hFFFF_FFFF: COUNT becomes 0 and ovf is set.
  - Else COUNT+1.
- Priorities within one edge:
  - A CPU write to COUNT overrides the tick update. No match or ovf is generated that cycle.
  - On STATUS, hardware set beats write-1-clear for the same bit.
  - A COMPARE write takes effect for the next tick; the current tick uses the old COMPARE.
- irq is combinational from registered state only: no path from addr or wdata. It stays high until software clears match or irqen.
- Reset asserted mid-operation: every state element returns to its reset value on that edge. An access in the same cycle is discarded.

Decomposition:
- Shared package mmio_timer_pkg holds:
  - register offsets OFF_CTRL, OFF_COUNT, OFF_COMPARE, OFF_STATUS, OFF_PRESCALE;
  - bit indices CTRL_EN, CTRL_IRQEN, CTRL_AUTO, ST_MATCH, ST_OVF;
  - the default BASE_ADDR.
- One sub-module, tick_gen (prescaler): inputs clock, reset, en, clr, presc[PRESC_W-1:0]; output tick.

Test Plan:
- Reset then read all five registers: the values read are CTRL=0, COUNT=0, COMPARE=FFFF_FFFF, STATUS=0, PRESCALE=0. rdata appears one cycle after rd, with hit=1.
- PRESCALE=3, CTRL=1, then run 40 cycles: COUNT increments every 4th cycle and reads 10 (±1 at the read-sample boundary). No ticks occur while en=0.
- Start from COUNT=0, PRESCALE=0. Write COMPARE=5, then CTRL=7 (en, irqen, autoreload): match sets on the tick where COUNT==5 and irq rises next cycle; COUNT sequence 4,5,0,1. Write STATUS=1: match and irq clear.
- COUNT=FFFF_FFFE, COMPARE=0, autoreload=0, en=1: ovf sets on wrap to 0. The next tick sees COUNT==0 and sets match; COUNT continues to 1.
- Same-edge collisions:
  - COUNT write of 0x100 on a tick edge: COUNT reads 0x100, not old+1.
  - W1C to STATUS.match on the same edge as a hardware set: match stays 1.
- Access to addr 0x0000_FF02 (unaligned) or 0x0000_FE04 (outside the window): no register changes, rdata=0, hit=0. Assert reset mid-count: all registers return to reset values on that edge.
